// File: rtl/dbus_pkg.sv
// dbus_pkg: address map, timer register offsets, region decode type and byte-lane merge helper
package dbus_pkg;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int DATA_WORDS = 4096;
  localparam logic [31:0] TIMER_BASE = 32'hFF20_0500;
  localparam logic [31:0] TIMER_SPAN = 32'h40;
  localparam logic [5:0] OFF_MTIME_LO = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI = 6'h04;
  localparam logic [5:0] OFF_CMP_LO = 6'h08;
  localparam logic [5:0] OFF_CMP_HI = 6'h0C;
  localparam logic [5:0] OFF_STATUS = 6'h10;
  localparam logic [5:0] OFF_RDCOUNT = 6'h20;
  localparam logic [5:0] OFF_WRCOUNT = 6'h24;
  typedef enum logic [1:0] {RGN_NONE, RGN_RAM, RGN_TIMER} region_e;
  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? nw[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/dbus_if.sv
// dbus_if: CPU data bus, master = processor core, slave = responder
interface dbus_if;
  logic DwReadEnable;
  logic DwWriteEnable;
  logic [3:0] DwByteEnable;
  logic [31:0] DwAddress;
  logic [31:0] DwWriteData;
  logic [31:0] DwReadData;
  modport master(output DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData, input DwReadData);
  modport slave(input DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData, output DwReadData);
endinterface

// File: rtl/dbus_timer.sv
// dbus_timer: 64-bit mtime/mtimecmp machine timer with sticky IRQ; DBUS_ACCESS_COUNT_EN adds access counters
module dbus_timer
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [3:0]  woff,
  input  logic [31:0] wdata,
`ifdef DBUS_ACCESS_COUNT_EN
  input  logic        mrd,
  input  logic        mwr,
`endif
  output logic [31:0] rdata,
  output logic        irq
);
  logic [63:0] mtime, mtimecmp, mtime_n, cmp_n;
  logic [5:0] off;
  logic pending, wr, clr;
  assign off = {woff, 2'b00};
  assign wr = sel & we;
  assign irq = pending;
  // a write to either mtime half replaces this cycle's increment
  always_comb begin
    mtime_n = wr && off == OFF_MTIME_LO ? {mtime[63:32], merge_be(mtime[31:0], wdata, be)}
            : wr && off == OFF_MTIME_HI ? {merge_be(mtime[63:32], wdata, be), mtime[31:0]}
            : mtime + 64'd1;
    cmp_n = wr && off == OFF_CMP_LO ? {mtimecmp[63:32], merge_be(mtimecmp[31:0], wdata, be)}
          : wr && off == OFF_CMP_HI ? {merge_be(mtimecmp[63:32], wdata, be), mtimecmp[31:0]}
          : mtimecmp;
    clr = wr && (off == OFF_CMP_LO || off == OFF_CMP_HI || (off == OFF_STATUS && be[0] && wdata[0]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      mtimecmp <= '1;
      pending <= 1'b0;
    end else begin
      mtime <= mtime_n;
      mtimecmp <= cmp_n;
      pending <= !clr && (pending || mtime >= mtimecmp);
    end
  end
`ifdef DBUS_ACCESS_COUNT_EN
  logic [31:0] rdcount, wrcount;
  always_ff @(posedge clk) begin
    if (rst) begin
      rdcount <= '0;
      wrcount <= '0;
    end else begin
      rdcount <= wr && off == OFF_RDCOUNT ? '0 : rdcount + 32'(mrd);
      wrcount <= wr && off == OFF_WRCOUNT ? '0 : wrcount + 32'(mwr);
    end
  end
`endif
  always_comb begin
    rdata = '0;
    case (off)
      OFF_MTIME_LO: rdata = mtime[31:0];
      OFF_MTIME_HI: rdata = mtime[63:32];
      OFF_CMP_LO:   rdata = mtimecmp[31:0];
      OFF_CMP_HI:   rdata = mtimecmp[63:32];
      OFF_STATUS:   rdata = {31'd0, pending};
`ifdef DBUS_ACCESS_COUNT_EN
      OFF_RDCOUNT:  rdata = rdcount;
      OFF_WRCOUNT:  rdata = wrcount;
`endif
      default:      rdata = '0;
    endcase
  end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: CPU data-bus slave with data RAM and machine timer; DBUS_ACCESS_COUNT_EN enables access counters
module data_bus_responder #(
  parameter logic [31:0] DATA_BASE = dbus_pkg::DATA_BASE,
  parameter int DATA_WORDS = dbus_pkg::DATA_WORDS,
  parameter logic [31:0] TIMER_BASE = dbus_pkg::TIMER_BASE
) (
  input  logic iCLK,
  input  logic iRST,
  dbus_if.slave bus,
  output logic oTimerIRQ,
  output logic oBusError
);
  import dbus_pkg::*;
  localparam int AW = $clog2(DATA_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_WORDS);
  logic [31:0] mem [DATA_WORDS];
  logic [31:0] tmr_rd;
  logic [AW-1:0] idx;
  logic [3:0] woff;
  region_e rgn;
  // unsigned offset subtraction wraps below the base, so one compare covers both bounds
  assign idx = AW'((bus.DwAddress - DATA_BASE) >> 2);
  assign woff = 4'((bus.DwAddress - TIMER_BASE) >> 2);
  always_comb rgn = (bus.DwAddress - DATA_BASE) < RAM_BYTES ? RGN_RAM
                  : (bus.DwAddress - TIMER_BASE) < TIMER_SPAN ? RGN_TIMER : RGN_NONE;
  always_comb bus.DwReadData = !bus.DwReadEnable ? '0
                             : rgn == RGN_RAM ? mem[idx]
                             : rgn == RGN_TIMER ? tmr_rd : '0;
  always_ff @(posedge iCLK) if (!iRST && bus.DwWriteEnable && rgn == RGN_RAM) mem[idx] <= merge_be(mem[idx], bus.DwWriteData, bus.DwByteEnable);
  always_ff @(posedge iCLK) oBusError <= !iRST && (bus.DwReadEnable || bus.DwWriteEnable) && rgn == RGN_NONE;
  dbus_timer u_timer (
    .clk(iCLK),
    .rst(iRST),
    .sel(rgn == RGN_TIMER),
    .we(bus.DwWriteEnable),
    .be(bus.DwByteEnable),
    .woff(woff),
    .wdata(bus.DwWriteData),
`ifdef DBUS_ACCESS_COUNT_EN
    .mrd(bus.DwReadEnable && rgn != RGN_NONE),
    .mwr(bus.DwWriteEnable && rgn != RGN_NONE),
`endif
    .rdata(tmr_rd),
    .irq(oTimerIRQ)
  );
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed self-checking bench for data_bus_responder; honours DBUS_ACCESS_COUNT_EN
module tb_data_bus_responder;
  localparam logic [31:0] T = 32'hFF20_0500;
  localparam logic [31:0] R = 32'h1001_0000;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic irq, berr;
  logic [31:0] rdv;
  int checks = 0;
  int errors = 0;
  dbus_if bus ();
  data_bus_responder dut (.iCLK(iCLK), .iRST(iRST), .bus(bus), .oTimerIRQ(irq), .oBusError(berr));
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic re, input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    bus.DwReadEnable = re;
    bus.DwWriteEnable = we;
    bus.DwByteEnable = be;
    bus.DwAddress = a;
    bus.DwWriteData = d;
    #1 rdv = bus.DwReadData;
    @(negedge iCLK);
    bus.DwReadEnable = 1'b0;
    bus.DwWriteEnable = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b0, 1'b1, be, a, d);
  endtask
  initial begin
    bus.DwReadEnable = 1'b0;
    bus.DwWriteEnable = 1'b0;
    bus.DwByteEnable = 4'h0;
    bus.DwAddress = 32'h0;
    bus.DwWriteData = 32'h0;
    repeat (2) @(negedge iCLK);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    rd(T);        chk("mtime_after5", rdv, 32'd5);
    rd(T + 8);    chk("cmp_lo_rst", rdv, 32'hFFFF_FFFF);
    rd(T + 12);   chk("cmp_hi_rst", rdv, 32'hFFFF_FFFF);
    rd(T + 16);   chk("status_rst", rdv, 32'd0);
    wr(R, 32'hAABB_CCDD, 4'b1111);
    wr(R, 32'h0000_1100, 4'b0010);
    rd(R);        chk("ram_be_merge", rdv, 32'hAABB_11DD);
    cyc(1'b1, 1'b1, 4'b1111, R, 32'h1234_5678);
    chk("ram_rw_old", rdv, 32'hAABB_11DD);
    rd(R);        chk("ram_rw_new", rdv, 32'h1234_5678);
    wr(R + 32'h3FFC, 32'hDEAD_BEEF, 4'b1111);
    rd(R + 32'h3FFC); chk("ram_last", rdv, 32'hDEAD_BEEF);
    chk("ram_last_berr", 32'(berr), 32'd0);
    rd(R + 32'h4000); chk("ram_past_end", rdv, 32'd0);
    chk("ram_past_berr", 32'(berr), 32'd1);
    wr(T, 32'd0, 4'b1111);
    wr(T + 12, 32'd0, 4'b1111);
    wr(T + 8, 32'd20, 4'b1111);
    chk("irq_cmp_loaded", 32'(irq), 32'd0);
    repeat (18) @(negedge iCLK);
    chk("irq_at_20", 32'(irq), 32'd0);
    rd(T);        chk("mtime_20", rdv, 32'd20);
    chk("irq_rise", 32'(irq), 32'd1);
    wr(T + 16, 32'd1, 4'b0001);
    chk("irq_w1c", 32'(irq), 32'd0);
    @(negedge iCLK);
    chk("irq_reset", 32'(irq), 32'd1);
    rd(T + 16);   chk("status_pend", rdv, 32'd1);
    wr(T, 32'hFFFF_FFFF, 4'b1111);
    wr(T + 4, 32'd0, 4'b1111);
    rd(T);        chk("mtime_wr_noinc", rdv, 32'hFFFF_FFFF);
    rd(T + 4);    chk("mtime_carry_hi", rdv, 32'd1);
    rd(T);        chk("mtime_carry_lo", rdv, 32'd1);
    wr(T + 4, 32'hFFFF_FFFF, 4'b1111);
    wr(T, 32'hFFFF_FFFF, 4'b1111);
    rd(T + 4);    chk("mtime_max_hi", rdv, 32'hFFFF_FFFF);
    rd(T + 4);    chk("mtime_wrap_hi", rdv, 32'd0);
    wr(T + 8, 32'h1122_3344, 4'b1000);
    rd(T + 8);    chk("cmp_be_merge", rdv, 32'h1100_0014);
    rd(32'h0);    chk("unmapped_rd", rdv, 32'd0);
    chk("berr_pulse", 32'(berr), 32'd1);
    rd(R);        chk("ram_after_berr", rdv, 32'h1234_5678);
    chk("berr_clear", 32'(berr), 32'd0);
    cyc(1'b0, 1'b0, 4'h0, R, 32'h0);
    chk("re_low_zero", rdv, 32'd0);
    rd(T + 20);   chk("tmr_hole", rdv, 32'd0);
    chk("tmr_hole_berr", 32'(berr), 32'd0);
`ifdef DBUS_ACCESS_COUNT_EN
    wr(T + 32, 32'd0, 4'b1111);
    wr(T + 36, 32'd0, 4'b1111);
    rd(R);
    rd(R + 4);
    rd(R + 8);
    wr(R + 4, 32'h5555_AAAA, 4'b1111);
    wr(R + 8, 32'hAAAA_5555, 4'b1111);
    rd(T + 32);   chk("rdcount", rdv, 32'd3);
    rd(T + 36);   chk("wrcount", rdv, 32'd2);
    wr(T + 36, 32'hFFFF_FFFF, 4'b1111);
    rd(T + 36);   chk("wrcount_clr", rdv, 32'd0);
`else
    rd(T + 32);   chk("rdcount_hole", rdv, 32'd0);
    chk("rdcount_hole_berr", 32'(berr), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
